sa_tile_core: RTL and testbench

- Parametrised successor to the square systolic core. Computes C[ROWS][COLS] = A[ROWS][K] x W[K][COLS] on a ROWS x COLS output-stationary PE array.
- Adds non-square geometry and per-lane input FIFOs with ready/valid handshake.
- Adds a runtime tile depth K, with start/busy/done control.
- Adds row-serial result drain with backpressure, plus accumulate-across-tiles mode.
- Sits between the DMA/wrapper and the PE array.

---
 rtl/sa_pkg.sv | 32 +++
 rtl/sa_lane_fifo.sv | 59 +++++
 rtl/sa_tile_core.sv | 257 +++++++++++++++++++++++++
 tb/tb_sa_tile_core.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic tile core.
//   sa_state_e : tile controller states
//   clog2      : ceiling log2, usable in parameter expressions
//   a_vec_t / w_vec_t / r_vec_t : lane bundles for the default 8x8, 8-bit in,
//                                 32-bit out build as seen by the DMA wrapper
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    TAIL,
    DRAIN
  } sa_state_e;

  // Returns the number of bits needed to index 'value' items (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DEF_ROWS     = 8;
  localparam int DEF_COLS     = 8;
  localparam int DEF_INWIDTH  = 8;
  localparam int DEF_OUTWIDTH = 32;

  typedef logic [DEF_ROWS-1:0][DEF_INWIDTH-1:0]  a_vec_t;
  typedef logic [DEF_COLS-1:0][DEF_INWIDTH-1:0]  w_vec_t;
  typedef logic [DEF_COLS-1:0][DEF_OUTWIDTH-1:0] r_vec_t;

endpackage

// File: rtl/sa_lane_fifo.sv
// Single-lane synchronous FIFO feeding one edge of the PE array.
//   clk, rstn : clock, synchronous active-low reset (empties the FIFO)
//   push, din : write one entry (caller guarantees !full)
//   pop, dout : dout shows the head entry; pop removes it (caller guarantees !empty)
//   full, empty : occupancy flags derived from an internal entry count
// DEPTH must be a power of two so the pointers wrap naturally.
module sa_lane_fifo
  import sa_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // NOTE: the storage array is deliberately not reset; the count and pointers
  // alone define which entries are valid, and an unreset array maps to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;  // idle, or push+pop leaves occupancy unchanged
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/sa_tile_core.sv
// Output-stationary systolic tile: C[ROWS][COLS] = A[ROWS][K] x W[K][COLS].
//   clk, rstn        : clock, synchronous active-low reset (aborts any tile)
//   start, k_len,    : begin a tile of depth k_len (1..KMAX); acc_mode=1 keeps
//   acc_mode           the accumulators from the previous tile
//   busy, done       : tile in progress / one-cycle pulse after the last row
//   in_valid/in_ready: one beat = a_data[r]=A[r][k], w_data[c]=W[k][c]
//   out_valid/ready  : row-serial drain; out_data[c]=C[out_row][c]
// Each input lane has its own FIFO; all lanes move in lockstep. A fire pops
// one beat into skew registers (row r delayed r, column c delayed c) so that
// A[r][k] and W[k][c] meet at PE(r,c). The skew and PE registers only move on
// a fire or during the flush tail, so an empty FIFO freezes the whole array.
module sa_tile_core
  import sa_pkg::*;
#(
  parameter  int ROWS       = 8,
  parameter  int COLS       = 8,
  parameter  int INWIDTH    = 8,
  parameter  int OUTWIDTH   = 32,
  parameter  int FIFO_DEPTH = 16,
  parameter  int KMAX       = 256,
  localparam int KW         = clog2(KMAX + 1),
  localparam int RW         = (ROWS > 1) ? clog2(ROWS) : 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [KW-1:0]                  k_len,
  input  logic                           acc_mode,
  output logic                           busy,
  output logic                           done,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ROWS-1:0][INWIDTH-1:0]   a_data,
  input  logic [COLS-1:0][INWIDTH-1:0]   w_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COLS-1:0][OUTWIDTH-1:0]  out_data,
  output logic [RW-1:0]                  out_row
);

  // Cycles needed after the last fire for that beat to reach PE(ROWS-1,COLS-1).
  localparam int TAIL_LEN = ROWS + COLS - 2;
  localparam int TW       = clog2(ROWS + COLS);

  sa_state_e       state, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [KW-1:0]   k_cnt, k_cnt_d;
  logic [TW-1:0]   tail_cnt, tail_cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic            done_q, done_d;
  logic            acc_clr;
  logic            k_ok;

  logic            push;
  logic            fire;
  logic            advance;
  logic [ROWS-1:0] a_full, a_empty;
  logic [COLS-1:0] w_full, w_empty;

  logic [INWIDTH-1:0]  a_head [ROWS];
  logic [INWIDTH-1:0]  w_head [COLS];
  logic [INWIDTH-1:0]  a_inj  [ROWS];
  logic [INWIDTH-1:0]  w_inj  [COLS];
  // a_bus[r][c] / w_bus[r][c] are the operands seen by PE(r,c); index c+1 / r+1
  // is that PE's registered pass-through to its neighbour.
  logic [INWIDTH-1:0]  a_bus  [ROWS][COLS+1];
  logic [INWIDTH-1:0]  w_bus  [ROWS+1][COLS];
  logic [OUTWIDTH-1:0] acc_bus [ROWS][COLS];

  // ---------------------------------------------------------------- input FIFOs
  assign in_ready = !(|{a_full, w_full});
  assign push     = in_valid && in_ready;
  assign fire     = (state == FIRE) && !(|{a_empty, w_empty});
  assign advance  = fire || (state == TAIL);

  for (genvar r = 0; r < ROWS; r++) begin : g_a_fifo
    sa_lane_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INWIDTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (fire),
      .din   (a_data[r]),
      .dout  (a_head[r]),
      .full  (a_full[r]),
      .empty (a_empty[r])
    );
    // Zeros flush the array during the tail and contribute nothing to C.
    assign a_inj[r] = fire ? a_head[r] : '0;
  end

  for (genvar c = 0; c < COLS; c++) begin : g_w_fifo
    sa_lane_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INWIDTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (fire),
      .din   (w_data[c]),
      .dout  (w_head[c]),
      .full  (w_full[c]),
      .empty (w_empty[c])
    );
    assign w_inj[c] = fire ? w_head[c] : '0;
  end

  // ------------------------------------------------------------ controller FSM
  assign k_ok = (k_len != '0) && (k_len <= KW'(KMAX));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      k_len_q  <= '0;
      k_cnt    <= '0;
      tail_cnt <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      k_len_q  <= k_len_d;
      k_cnt    <= k_cnt_d;
      tail_cnt <= tail_cnt_d;
      row_q    <= row_d;
      done_q   <= done_d;
    end
  end

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state;
    k_len_d    = k_len_q;
    k_cnt_d    = k_cnt;
    tail_cnt_d = tail_cnt;
    row_d      = row_q;
    done_d     = 1'b0;
    acc_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (start && k_ok) begin
          state_d = FIRE;
          k_len_d = k_len;
          k_cnt_d = '0;
          acc_clr = !acc_mode;
        end
      end
      FIRE: begin
        if (fire) begin
          k_cnt_d = k_cnt + KW'(1);
          if (k_cnt == k_len_q - KW'(1)) begin
            k_cnt_d = '0;
            if (TAIL_LEN == 0) begin
              state_d = DRAIN;
            end else begin
              state_d    = TAIL;
              tail_cnt_d = TW'(TAIL_LEN);
            end
          end
        end
      end
      TAIL: begin
        tail_cnt_d = tail_cnt - TW'(1);
        if (tail_cnt == TW'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign out_valid = (state == DRAIN);
  assign out_row   = row_q;

  // ------------------------------------------------------------ skew registers
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_direct
      assign a_bus[r][0] = a_inj[r];
    end else begin : g_dly
      logic [INWIDTH-1:0] sr [r];
      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else if (advance) begin
          sr[0] <= a_inj[r];
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign a_bus[r][0] = sr[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_w_skew
    if (c == 0) begin : g_direct
      assign w_bus[0][c] = w_inj[c];
    end else begin : g_dly
      logic [INWIDTH-1:0] sr [c];
      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int i = 0; i < c; i++) sr[i] <= '0;
        end else if (advance) begin
          sr[0] <= w_inj[c];
          for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      end
      assign w_bus[0][c] = sr[c-1];
    end
  end

  // ------------------------------------------------------------------ PE array
  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe_col
      logic signed [2*INWIDTH-1:0] prod;
      logic signed [OUTWIDTH-1:0]  prod_ext;
      logic [INWIDTH-1:0]          a_q, w_q;
      logic [OUTWIDTH-1:0]         acc_q;

      assign prod     = $signed(a_bus[r][c]) * $signed(w_bus[r][c]);
      assign prod_ext = OUTWIDTH'(prod);  // sign-extends the signed product

      always_ff @(posedge clk) begin
        if (!rstn) begin
          a_q   <= '0;
          w_q   <= '0;
          acc_q <= '0;
        end else begin
          if (advance) begin
            a_q <= a_bus[r][c];
            w_q <= w_bus[r][c];
          end
          // acc_clr only occurs in IDLE and advance never does, so they never collide.
          if (acc_clr)      acc_q <= '0;
          else if (advance) acc_q <= acc_q + prod_ext;  // wraps modulo 2^OUTWIDTH
        end
      end

      assign a_bus[r][c+1] = a_q;
      assign w_bus[r+1][c] = w_q;
      assign acc_bus[r][c] = acc_q;
    end
  end

  // ------------------------------------------------------------- result drain
  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++) out_data[c] = acc_bus[row_q][c];
  end

endmodule

// File: tb/tb_sa_tile_core.sv
// Scoreboard bench for sa_tile_core. Two instances share clk/rstn:
//   d0: 2x2, 8-bit in, 32-bit out, 16-deep FIFOs, KMAX=256
//   d1: 2x3, 8-bit in, 16-bit out,  4-deep FIFOs, KMAX=8
// Expected result rows are queued when a tile is issued; per-instance monitors
// pop and compare each accepted output row.
module tb_sa_tile_core;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---- d0 signals
  logic             s0_start, s0_acc_mode, s0_busy, s0_done;
  logic [8:0]       s0_k_len;
  logic             s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [1:0][7:0]  s0_a, s0_w;
  logic [1:0][31:0] s0_out_data;
  logic [0:0]       s0_out_row;

  // ---- d1 signals
  logic             s1_start, s1_acc_mode, s1_busy, s1_done;
  logic [3:0]       s1_k_len;
  logic             s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [1:0][7:0]  s1_a;
  logic [2:0][7:0]  s1_w;
  logic [2:0][15:0] s1_out_data;
  logic [0:0]       s1_out_row;

  sa_tile_core #(.ROWS(2), .COLS(2), .INWIDTH(8), .OUTWIDTH(32),
                 .FIFO_DEPTH(16), .KMAX(256)) d0 (
    .clk(clk), .rstn(rstn), .start(s0_start), .k_len(s0_k_len),
    .acc_mode(s0_acc_mode), .busy(s0_busy), .done(s0_done),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .a_data(s0_a), .w_data(s0_w),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .out_row(s0_out_row)
  );

  sa_tile_core #(.ROWS(2), .COLS(3), .INWIDTH(8), .OUTWIDTH(16),
                 .FIFO_DEPTH(4), .KMAX(8)) d1 (
    .clk(clk), .rstn(rstn), .start(s1_start), .k_len(s1_k_len),
    .acc_mode(s1_acc_mode), .busy(s1_busy), .done(s1_done),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .a_data(s1_a), .w_data(s1_w),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
    .out_row(s1_out_row)
  );

  typedef struct packed {
    logic [0:0]  row;
    logic [63:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] row2(input int c0, input int c1);
    logic [1:0][31:0] v;
    v[0] = 32'(c0);
    v[1] = 32'(c1);
    return 64'(v);
  endfunction

  function automatic logic [63:0] row3(input int c0, input int c1, input int c2);
    logic [2:0][15:0] v;
    v[0] = 16'(c0);
    v[1] = 16'(c1);
    v[2] = 16'(c2);
    return 64'(v);
  endfunction

  // ---- monitors
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rstn && s0_out_valid && s0_out_ready) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL d0_unexpected_row: got row %0d data 0x%0h expected none", s0_out_row, s0_out_data);
      end else begin
        e = q0.pop_front();
        check("d0_row_index", 64'(s0_out_row), 64'(e.row));
        check("d0_row_data", 64'(s0_out_data), e.data);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rstn && s1_out_valid && s1_out_ready) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL d1_unexpected_row: got row %0d data 0x%0h expected none", s1_out_row, s1_out_data);
      end else begin
        e = q1.pop_front();
        check("d1_row_index", 64'(s1_out_row), 64'(e.row));
        check("d1_row_data", 64'(s1_out_data), e.data);
      end
    end
  end

  // ---- stimulus helpers (called at #1 after a rising edge)
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push0(input int a0, input int a1, input int w0, input int w1);
    int i;
    s0_a[0] = 8'(a0); s0_a[1] = 8'(a1);
    s0_w[0] = 8'(w0); s0_w[1] = 8'(w1);
    s0_in_valid = 1'b1;
    for (i = 0; i < 200 && !s0_in_ready; i++) cycles(1);
    if (i == 200) begin
      n_tests++; n_fail++;
      $display("FAIL d0_push_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
    cycles(1);
    s0_in_valid = 1'b0;
  endtask

  task automatic push1(input int a0, input int a1, input int w0, input int w1, input int w2);
    int i;
    s1_a[0] = 8'(a0); s1_a[1] = 8'(a1);
    s1_w[0] = 8'(w0); s1_w[1] = 8'(w1); s1_w[2] = 8'(w2);
    s1_in_valid = 1'b1;
    for (i = 0; i < 200 && !s1_in_ready; i++) cycles(1);
    if (i == 200) begin
      n_tests++; n_fail++;
      $display("FAIL d1_push_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
    cycles(1);
    s1_in_valid = 1'b0;
  endtask

  task automatic start0(input int k, input logic acc);
    s0_k_len = 9'(k); s0_acc_mode = acc; s0_start = 1'b1;
    cycles(1);
    s0_start = 1'b0;
  endtask

  task automatic start1(input int k, input logic acc);
    s1_k_len = 4'(k); s1_acc_mode = acc; s1_start = 1'b1;
    cycles(1);
    s1_start = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the start edge. exp_* <= 0 means the
  // latency is not checked, only that done arrives within the budget.
  task automatic run_tile(input int sel, input int exp_valid, input int exp_done, input string tag);
    int first_valid;
    int done_cyc;
    first_valid = -1;
    done_cyc    = -1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (first_valid < 0 && ((sel == 0) ? s0_out_valid : s1_out_valid)) first_valid = cyc;
      if ((sel == 0) ? s0_done : s1_done) begin
        done_cyc = cyc;
        break;
      end
      cycles(1);
    end
    if (exp_valid > 0) check({tag, "_first_valid_cycle"}, 64'(first_valid), 64'(exp_valid));
    if (exp_done > 0)  check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    else               check({tag, "_done_seen"}, 64'(done_cyc > 0), 64'd1);
    check({tag, "_busy_at_done"}, 64'((sel == 0) ? s0_busy : s1_busy), 64'd0);
  endtask

  task automatic tile0_data();
    push0(1, 3, 5, 6);
    push0(2, 4, 7, 8);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int dcount;
    int w;
    s0_start = 0; s0_k_len = '0; s0_acc_mode = 0; s0_in_valid = 0;
    s0_a = '0; s0_w = '0; s0_out_ready = 1;
    s1_start = 0; s1_k_len = '0; s1_acc_mode = 0; s1_in_valid = 0;
    s1_a = '0; s1_w = '0; s1_out_ready = 1;

    cycles(3);
    rstn = 1'b1;
    cycles(1);

    // Reset state
    check("d0_reset_busy",      64'(s0_busy),      64'd0);
    check("d0_reset_done",      64'(s0_done),      64'd0);
    check("d0_reset_out_valid", 64'(s0_out_valid), 64'd0);
    check("d0_reset_out_row",   64'(s0_out_row),   64'd0);
    check("d0_reset_in_ready",  64'(s0_in_ready),  64'd1);
    check("d1_reset_in_ready",  64'(s1_in_ready),  64'd1);

    // 2x2 basic tile, prefilled, out_ready high: valid at 5, done at 7
    tile0_data();
    q0.push_back('{row: 1'b0, data: row2(19, 22)});
    q0.push_back('{row: 1'b1, data: row2(43, 50)});
    start0(2, 1'b0);
    run_tile(0, 5, 7, "d0_basic");

    // Backpressure: row 0 held for 5 cycles
    tile0_data();
    q0.push_back('{row: 1'b0, data: row2(19, 22)});
    q0.push_back('{row: 1'b1, data: row2(43, 50)});
    s0_out_ready = 1'b0;
    start0(2, 1'b0);
    for (w = 0; w < 100 && !s0_out_valid; w++) cycles(1);
    check("d0_stall_valid_seen", 64'(s0_out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("d0_stall_row",  64'(s0_out_row),  64'd0);
      check("d0_stall_data", 64'(s0_out_data), row2(19, 22));
      check("d0_stall_done", 64'(s0_done),     64'd0);
      cycles(1);
    end
    s0_out_ready = 1'b1;
    run_tile(0, 0, 0, "d0_stall");

    // Accumulate mode doubles the previous tile, then a clearing tile
    tile0_data();
    q0.push_back('{row: 1'b0, data: row2(38, 44)});
    q0.push_back('{row: 1'b1, data: row2(86, 100)});
    start0(2, 1'b1);
    run_tile(0, 5, 7, "d0_acc");
    tile0_data();
    q0.push_back('{row: 1'b0, data: row2(19, 22)});
    q0.push_back('{row: 1'b1, data: row2(43, 50)});
    start0(2, 1'b0);
    run_tile(0, 5, 7, "d0_clear");

    // Illegal depths are ignored
    start0(0, 1'b0);
    check("d0_klen0_busy_1", 64'(s0_busy), 64'd0);
    cycles(2);
    check("d0_klen0_busy_3", 64'(s0_busy), 64'd0);
    start0(300, 1'b0);
    check("d0_klen_big_busy", 64'(s0_busy), 64'd0);
    start1(9, 1'b0);
    check("d1_klen_big_busy", 64'(s1_busy), 64'd0);

    // 2x3, K=3, start on empty FIFOs, beats gapped every other cycle
    q1.push_back('{row: 1'b0, data: row3(-5, -3, -1)});
    q1.push_back('{row: 1'b1, data: row3(14, 15, 16)});
    start1(3, 1'b0);
    push1( 1,  0,  1, 2, 3); cycles(1);
    push1(-1,  3,  4, 5, 6); cycles(1);
    push1( 2, -2, -1, 0, 1);
    run_tile(1, 0, 0, "d1_gapped");

    // Wrap: K=3 of 127*127 in 16 bits, prefilled: valid at 7, done at 9
    for (int i = 0; i < 3; i++) push1(127, 127, 127, 127, 127);
    q1.push_back('{row: 1'b0, data: row3(48387, 48387, 48387)});
    q1.push_back('{row: 1'b1, data: row3(48387, 48387, 48387)});
    start1(3, 1'b0);
    run_tile(1, 7, 9, "d1_wrap127");

    // Depth-4 FIFO full, then K=5 of -128*-128 with the 5th beat streamed in
    for (int i = 0; i < 4; i++) push1(-128, -128, -128, -128, -128);
    check("d1_full_in_ready", 64'(s1_in_ready), 64'd0);
    s1_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      check("d1_full_hold_in_ready", 64'(s1_in_ready), 64'd0);
    end
    q1.push_back('{row: 1'b0, data: row3(16384, 16384, 16384)});
    q1.push_back('{row: 1'b1, data: row3(16384, 16384, 16384)});
    start1(5, 1'b0);
    check("d1_first_fire_in_ready", 64'(s1_in_ready), 64'd0);
    push1(-128, -128, -128, -128, -128);
    run_tile(1, 0, 0, "d1_wrap128");

    // Reset in the middle of a stalled FIRE: abort, no done, FIFOs emptied
    push1(7, 7, 7, 7, 7);
    push1(7, 7, 7, 7, 7);
    start1(3, 1'b0);
    cycles(2);
    check("d1_abort_busy_before", 64'(s1_busy), 64'd1);
    rstn = 1'b0;
    cycles(1);
    rstn = 1'b1;
    check("d1_abort_busy",      64'(s1_busy),      64'd0);
    check("d1_abort_in_ready",  64'(s1_in_ready),  64'd1);
    check("d1_abort_out_valid", 64'(s1_out_valid), 64'd0);
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (s1_done) dcount++;
      cycles(1);
    end
    check("d1_abort_no_done", 64'(dcount), 64'd0);
    push1( 1,  0,  1, 2, 3);
    push1(-1,  3,  4, 5, 6);
    push1( 2, -2, -1, 0, 1);
    q1.push_back('{row: 1'b0, data: row3(-5, -3, -1)});
    q1.push_back('{row: 1'b1, data: row3(14, 15, 16)});
    start1(3, 1'b0);
    run_tile(1, 7, 9, "d1_after_abort");

    cycles(3);
    check("d0_queue_drained", 64'(q0.size()), 64'd0);
    check("d1_queue_drained", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
